regfile_read_sequencer: RTL

REGFILE_READ_SEQUENCER -- requirements
Module: regfile_read_sequencer

---
 rtl/regfile_read_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/regfile_read_sequencer.sv
// rtl/regfile_read_sequencer.sv - gathers up to three register-file operands (A/B/C) through a single read port.
module regfile_read_sequencer #(
  parameter int PC_OFFSET = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_mask,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rm,
  input  logic [3:0]  req_rs,
  input  logic        flush,
  output logic        rf_read_en,
  output logic [3:0]  rf_read_reg,
  input  logic [31:0] rf_read_value,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] op_c
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  localparam logic [31:0] PC_ADJ = 32'(PC_OFFSET);

  state_e      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic        pend_q, pend_d;
  logic [1:0]  pend_slot_q, pend_slot_d;
  logic [2:0]  mask_q, mask_d;
  logic [3:0]  rn_q, rn_d, rm_q, rm_d, rs_q, rs_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;

  logic        accept;
  logic        has_next;
  logic [1:0]  first_slot, next_slot;
  logic [3:0]  issue_reg, pend_reg;
  logic [31:0] cap_value;

  assign req_ready   = (state_q == IDLE) && !flush;
  assign accept      = req_valid && req_ready;
  assign rf_read_en  = (state_q == READ);
  assign rf_read_reg = rf_read_en ? issue_reg : 4'd0;
  assign op_valid    = (state_q == DONE);
  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign op_c        = op_c_q;

  always_comb begin
    case (slot_q)
      2'd0:    issue_reg = rn_q;
      2'd1:    issue_reg = rm_q;
      default: issue_reg = rs_q;
    endcase
    case (pend_slot_q)
      2'd0:    pend_reg = rn_q;
      2'd1:    pend_reg = rm_q;
      default: pend_reg = rs_q;
    endcase
    // R15 reads see the pipelined PC, not the architectural value
    cap_value = rf_read_value + ((pend_reg == 4'd15) ? PC_ADJ : 32'd0);
  end

  // slot_q always points at a set mask bit while in READ
  always_comb begin
    first_slot = req_mask[0] ? 2'd0 : (req_mask[1] ? 2'd1 : 2'd2);
    case (slot_q)
      2'd0: begin
        has_next  = mask_q[1] || mask_q[2];
        next_slot = mask_q[1] ? 2'd1 : 2'd2;
      end
      2'd1: begin
        has_next  = mask_q[2];
        next_slot = 2'd2;
      end
      default: begin
        has_next  = 1'b0;
        next_slot = 2'd2;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    pend_d      = 1'b0;
    pend_slot_d = pend_slot_q;
    mask_d      = mask_q;
    rn_d        = rn_q;
    rm_d        = rm_q;
    rs_d        = rs_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_c_d      = op_c_q;

    if (pend_q && !flush) begin
      case (pend_slot_q)
        2'd0:    op_a_d = cap_value;
        2'd1:    op_b_d = cap_value;
        default: op_c_d = cap_value;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          mask_d  = req_mask;
          rn_d    = req_rn;
          rm_d    = req_rm;
          rs_d    = req_rs;
          op_a_d  = 32'd0;
          op_b_d  = 32'd0;
          op_c_d  = 32'd0;
          slot_d  = first_slot;
          state_d = (req_mask == 3'b000) ? DONE : READ;
        end
      end
      READ: begin
        pend_d      = 1'b1;
        pend_slot_d = slot_q;
        if (has_next) slot_d = next_slot;
        else          state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        if (op_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_q      <= 2'd0;
      pend_q      <= 1'b0;
      pend_slot_q <= 2'd0;
      mask_q      <= 3'd0;
      rn_q        <= 4'd0;
      rm_q        <= 4'd0;
      rs_q        <= 4'd0;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      op_c_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      pend_q      <= pend_d;
      pend_slot_q <= pend_slot_d;
      mask_q      <= mask_d;
      rn_q        <= rn_d;
      rm_q        <= rm_d;
      rs_q        <= rs_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_c_q      <= op_c_d;
    end
  end

endmodule
